// File: rtl/spi_req_arbiter.sv
// Two-requester round-robin arbiter that sequences one SPI master: load, transfer, ack, then a cs_n gap.
// Optional XFER watchdog is compiled in with `define SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter #(
    parameter int CS_GAP         = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] tx0,
    input  logic [7:0] tx1,
    input  logic [1:0] cfg0,
    input  logic [1:0] cfg1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rx_data,
    output logic       err,
    output logic       busy,
    output logic       cs_n,
    output logic [7:0] data_out,
    output logic       cpol_out,
    output logic       cpha_out,
    input  logic       tx_done,
    input  logic [7:0] p_in
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_XFER = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam logic [3:0]  GAP_LAST  = 4'(CS_GAP - 1);
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    if (CS_GAP < 1 || CS_GAP > 15 || TIMEOUT_CYCLES < 15 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("spi_req_arbiter: CS_GAP or TIMEOUT_CYCLES out of range");
    end

    logic [2:0] state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       cs_n_q, cs_n_d;
    logic [7:0] data_q, data_d;
    logic       cpol_q, cpol_d;
    logic       cpha_q, cpha_d;
    logic [7:0] rx_q, rx_d;
    logic       ack_q, ack_d;
`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        gap_cnt_d    = gap_cnt_q;
        cs_n_d       = cs_n_q;
        data_d       = data_q;
        cpol_d       = cpol_q;
        cpha_d       = cpha_q;
        rx_d         = rx_q;
        ack_d        = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        wdog_d       = wdog_q;
        err_d        = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // On a tie, serve whoever was not served last.
                    grant_d      = (req0 && req1) ? ~last_grant_q : req1;
                    last_grant_d = grant_d;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                data_d           = grant_q ? tx1 : tx0;
                {cpol_d, cpha_d} = grant_q ? cfg1 : cfg0;
                cs_n_d           = 1'b0;
                state_d          = S_XFER;
`ifdef SPI_ARB_TIMEOUT_EN
                wdog_d           = 16'd0;
`endif
            end
            S_XFER: begin
                if (tx_done) begin
                    rx_d    = p_in;
                    ack_d   = 1'b1;
                    cs_n_d  = 1'b1;
                    state_d = S_DONE;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    rx_d    = 8'hFF;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    cs_n_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
`endif
            end
            S_DONE: begin
                gap_cnt_d = 4'd0;
                state_d   = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = 4'd0;
                    state_d   = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            gap_cnt_q    <= 4'd0;
            cs_n_q       <= 1'b1;
            data_q       <= 8'd0;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            rx_q         <= 8'd0;
            ack_q        <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            wdog_q       <= 16'd0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            gap_cnt_q    <= gap_cnt_d;
            cs_n_q       <= cs_n_d;
            data_q       <= data_d;
            cpol_q       <= cpol_d;
            cpha_q       <= cpha_d;
            rx_q         <= rx_d;
            ack_q        <= ack_d;
`ifdef SPI_ARB_TIMEOUT_EN
            wdog_q       <= wdog_d;
            err_q        <= err_d;
`endif
        end
    end

    // grant_q is frozen from LOAD through GAP, so it steers the single ack pulse.
    assign ack0     = ack_q & ~grant_q;
    assign ack1     = ack_q & grant_q;
    assign rx_data  = rx_q;
    assign busy     = (state_q != S_IDLE);
    assign cs_n     = cs_n_q;
    assign data_out = data_q;
    assign cpol_out = cpol_q;
    assign cpha_out = cpha_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: a vector table of transactions plus hand-written corner sequences.
module tb_spi_req_arbiter;

    localparam int CS_GAP = 4;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int N0 = 14;
`else
    localparam int N0 = 20;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] tx0 = 8'h00, tx1 = 8'h00;
    logic [1:0] cfg0 = 2'b00, cfg1 = 2'b00;
    logic       ack0, ack1, err, busy, cs_n, cpol_out, cpha_out;
    logic [7:0] rx_data, data_out;
    logic       tx_done = 1'b0;
    logic [7:0] p_in = 8'h00;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_req_arbiter #(.CS_GAP(CS_GAP), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .tx0(tx0), .tx1(tx1), .cfg0(cfg0), .cfg1(cfg1),
        .ack0(ack0), .ack1(ack1), .rx_data(rx_data), .err(err), .busy(busy),
        .cs_n(cs_n), .data_out(data_out), .cpol_out(cpol_out), .cpha_out(cpha_out),
        .tx_done(tx_done), .p_in(p_in)
    );

    typedef struct {
        bit         do_rst;
        bit         chk_gap;
        bit         r0, r1;
        logic [7:0] t0, t1;
        logic [1:0] c0, c1;
        logic [7:0] pin;
        int         n;
        bit         g;
        logic [7:0] e_data;
        logic       e_cpol, e_cpha;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; tx_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_data_out", data_out, 0);
        chk("rst_cpol", cpol_out, 0);
        chk("rst_cpha", cpha_out, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_acks", {ack0, ack1}, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
    endtask

    task automatic wait_cs_low(output int hi);
        hi = 0;
        while (cs_n !== 1'b0 && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        if (hi >= 40) chk("cs_low_wait_expired", 1, 0);
    endtask

    // tx_done stays low for n XFER cycles and is raised on the (n+1)th; ends at the DONE negedge.
    task automatic xfer(input int n, input logic [7:0] pin, output int low);
        low = 0;
        p_in = pin;
        for (int k = 1; k <= n + 1; k++) begin
            if (cs_n === 1'b0) low++;
            tx_done = (k == n + 1);
            @(negedge clk);
        end
        tx_done = 1'b0;
    endtask

    task automatic check_done(input bit g, input logic [7:0] rx, input logic e_err);
        chk("done_ack0", ack0, !g);
        chk("done_ack1", ack1, g);
        chk("done_rx_data", rx_data, rx);
        chk("done_err", err, e_err);
        chk("done_cs_n", cs_n, 1);
        chk("done_busy", busy, 1);
        @(negedge clk);
        chk("ack_single_pulse", {ack0, ack1}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        int hi, low;
        bit seen_ack;
        vecs[0] = '{1, 0, 1, 0, 8'hA5, 8'h00, 2'b10, 2'b00, 8'h3C, N0, 0, 8'hA5, 1, 0};
        vecs[1] = '{1, 0, 1, 1, 8'h11, 8'h22, 2'b00, 2'b11, 8'h81, 3,  0, 8'h11, 0, 0};
        vecs[2] = '{0, 1, 1, 1, 8'h11, 8'h22, 2'b00, 2'b11, 8'h42, 5,  1, 8'h22, 1, 1};
        vecs[3] = '{0, 1, 1, 1, 8'h33, 8'h22, 2'b01, 2'b11, 8'h7E, 0,  0, 8'h33, 0, 1};
        vecs[4] = '{0, 1, 1, 1, 8'h33, 8'h44, 2'b01, 2'b10, 8'hC3, 2,  1, 8'h44, 1, 0};
        vecs[5] = '{0, 1, 0, 1, 8'h33, 8'h5A, 2'b01, 2'b01, 8'h00, 1,  1, 8'h5A, 0, 1};
        vecs[6] = '{0, 1, 1, 0, 8'hFF, 8'h5A, 2'b11, 2'b01, 8'hFF, 7,  0, 8'hFF, 1, 1};

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].do_rst) do_reset();
            req0 = vecs[i].r0; req1 = vecs[i].r1;
            tx0 = vecs[i].t0; tx1 = vecs[i].t1;
            cfg0 = vecs[i].c0; cfg1 = vecs[i].c1;
            wait_cs_low(hi);
            if (vecs[i].chk_gap) begin
                checks++;
                if (hi + 1 < CS_GAP + 3) begin
                    errors++;
                    $display("FAIL vec%0d_cs_gap: got %0d high cycles expected >= %0d", i, hi + 1, CS_GAP + 3);
                end
            end
            chk($sformatf("vec%0d_data_out", i), data_out, vecs[i].e_data);
            chk($sformatf("vec%0d_cpol", i), cpol_out, vecs[i].e_cpol);
            chk($sformatf("vec%0d_cpha", i), cpha_out, vecs[i].e_cpha);
            chk($sformatf("vec%0d_busy", i), busy, 1);
            xfer(vecs[i].n, vecs[i].pin, low);
            chk($sformatf("vec%0d_cs_low_cycles", i), low, vecs[i].n + 1);
            chk($sformatf("vec%0d_data_held", i), data_out, vecs[i].e_data);
            check_done(vecs[i].g, vecs[i].pin, 0);
            $display("vec%0d grant=%0d data_out=%h rx=%h cs_low=%0d", i, vecs[i].g, vecs[i].e_data, vecs[i].pin, low);
        end

        // tx_done pulses in GAP and then IDLE must be ignored.
        req0 = 1'b0; req1 = 1'b0;
        seen_ack = 1'b0;
        repeat (8) begin
            tx_done = 1'b1;
            @(negedge clk);
            if (ack0 || ack1) seen_ack = 1'b1;
        end
        tx_done = 1'b0;
        chk("stray_tx_done_ack", seen_ack, 0);
        chk("stray_tx_done_busy", busy, 0);
        chk("stray_tx_done_cs_n", cs_n, 1);
        $display("stray tx_done in GAP/IDLE busy=%0d", busy);

        // Request withdrawn after grant still completes.
        req1 = 1'b1; tx1 = 8'h96; cfg1 = 2'b00;
        wait_cs_low(hi);
        req1 = 1'b0;
        chk("drop_data_out", data_out, 8'h96);
        xfer(4, 8'h69, low);
        chk("drop_cs_low_cycles", low, 5);
        check_done(1, 8'h69, 0);
        $display("dropped req1 grant=1 rx=69");

        // Reset five cycles into XFER.
        req0 = 1'b1; tx0 = 8'h5C; cfg0 = 2'b11;
        wait_cs_low(hi);
        repeat (5) @(negedge clk);
        chk("pre_rst_cs_n", cs_n, 0);
        rst = 1'b0; req0 = 1'b0;
        @(negedge clk);
        chk("mid_rst_cs_n", cs_n, 1);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        seen_ack = 1'b0;
        repeat (20) begin
            tx_done = 1'b1;
            @(negedge clk);
            if (ack0 || ack1) seen_ack = 1'b1;
        end
        tx_done = 1'b0;
        chk("mid_rst_no_ack", seen_ack, 0);
        $display("reset mid-XFER cs_n=%0d busy=%0d", cs_n, busy);

        // Requester never sees tx_done.
        req0 = 1'b1; tx0 = 8'hE7; cfg0 = 2'b01;
        wait_cs_low(hi);
        req0 = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        low = 0;
        repeat (15) begin
            if (cs_n === 1'b0) low++;
            @(negedge clk);
        end
        chk("tmo_cs_low_cycles", low, 15);
        check_done(0, 8'hFF, 1);
        $display("timeout ack0 err=1 rx=FF");
`else
        seen_ack = 1'b0;
        low = 0;
        repeat (40) begin
            if (cs_n === 1'b0 && busy === 1'b1) low++;
            if (ack0 || ack1) seen_ack = 1'b1;
            @(negedge clk);
        end
        chk("no_tmo_held_in_xfer", low, 40);
        chk("no_tmo_no_ack", seen_ack, 0);
        $display("no watchdog: held in XFER for %0d cycles", low);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
